// File: rtl/udp_tx_serializer.sv
// udp_tx_serializer
//   Takes a header command plus a stream of BYTES_PER_BEAT-wide payload beats
//   and hands the packet to a UDP layer one byte at a time.
//
//   Ports
//     clk, reset            clock, async active-low reset
//     cmd_*                 header command (valid/ready); cmd_len in bytes
//     in_data/valid/ready   payload beats, lane 0 (bits 7:0) goes out first
//     udp_tx_start          one-cycle header strobe; udp_hdr_* hold the header
//     udp_tx_data_out_ready UDP layer accepts the presented byte
//     udp_tx_result         00 none, 01 sending, 10 error, 11 sent
//     data_out/_valid/_last registered payload byte stream
//     busy                  FSM not idle
//     done_pulse/err_pulse  one-cycle packet outcome strobes
//     pkt_cnt/err_cnt       wrapping outcome counters
module udp_tx_serializer #(
  parameter int BYTES_PER_BEAT = 4,
  parameter int RESULT_TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [31:0]                 cmd_dst_ip,
  input  logic [15:0]                 cmd_dst_port,
  input  logic [15:0]                 cmd_src_port,
  input  logic [15:0]                 cmd_len,
  input  logic [8*BYTES_PER_BEAT-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        udp_tx_start,
  output logic [31:0]                 udp_hdr_dst_ip,
  output logic [15:0]                 udp_hdr_dst_port,
  output logic [15:0]                 udp_hdr_src_port,
  output logic [15:0]                 udp_hdr_data_length,
  input  logic                        udp_tx_data_out_ready,
  input  logic [1:0]                  udp_tx_result,
  output logic [7:0]                  data_out,
  output logic                        data_out_valid,
  output logic                        data_out_last,
  output logic                        busy,
  output logic                        done_pulse,
  output logic                        err_pulse,
  output logic [15:0]                 pkt_cnt,
  output logic [15:0]                 err_cnt
);
  localparam int LW = (BYTES_PER_BEAT > 1) ? $clog2(BYTES_PER_BEAT) : 1;
  localparam int TW = $clog2(RESULT_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, START, DATA, RESULT, FLUSH} state_t;

  state_t                              state;
  logic [BYTES_PER_BEAT-1:0][7:0]      lane_buf;
  logic [LW-1:0]                       lane_idx;
  logic [LW:0]                         buf_cnt;     // lanes still waiting in lane_buf
  logic [15:0]                         rem;         // bytes not yet loaded into data_out
  logic [15:0]                         beats_owed;  // beats still to consume this packet
  logic [TW-1:0]                       tmo;

  logic        res_err, xfer, out_free, beat_take;
  logic [LW:0] beat_bytes;
  logic [15:0] cmd_beats;

  assign res_err   = (udp_tx_result == 2'b10);
  assign xfer      = data_out_valid & udp_tx_data_out_ready;
  assign out_free  = ~data_out_valid | xfer;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // In DATA a beat is only taken once the buffer has drained; a beat offered
  // on the cycle an error is reported is left for FLUSH to swallow.
  assign in_ready  = ((state == DATA) && (buf_cnt == '0) && (beats_owed != '0) && !res_err) ||
                     ((state == FLUSH) && (beats_owed != '0));
  assign beat_take = in_valid & in_ready;

  // Bytes of the incoming beat that belong to the packet; the rest are dropped.
  assign beat_bytes = (rem < 16'(BYTES_PER_BEAT)) ? rem[LW:0] : (LW+1)'(BYTES_PER_BEAT);
  assign cmd_beats  = cmd_len / 16'(BYTES_PER_BEAT) +
                      16'(|(cmd_len % 16'(BYTES_PER_BEAT)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      lane_buf            <= '0;
      lane_idx            <= '0;
      buf_cnt             <= '0;
      rem                 <= '0;
      beats_owed          <= '0;
      tmo                 <= '0;
      udp_tx_start        <= 1'b0;
      udp_hdr_dst_ip      <= '0;
      udp_hdr_dst_port    <= '0;
      udp_hdr_src_port    <= '0;
      udp_hdr_data_length <= '0;
      data_out            <= '0;
      data_out_valid      <= 1'b0;
      data_out_last       <= 1'b0;
      done_pulse          <= 1'b0;
      err_pulse           <= 1'b0;
      pkt_cnt             <= '0;
      err_cnt             <= '0;
    end else begin
      udp_tx_start <= 1'b0;
      done_pulse   <= 1'b0;
      err_pulse    <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          if (cmd_len == '0) begin
            err_pulse <= 1'b1;
            err_cnt   <= err_cnt + 16'd1;
          end else begin
            udp_hdr_dst_ip      <= cmd_dst_ip;
            udp_hdr_dst_port    <= cmd_dst_port;
            udp_hdr_src_port    <= cmd_src_port;
            udp_hdr_data_length <= cmd_len;
            rem                 <= cmd_len;
            beats_owed          <= cmd_beats;
            buf_cnt             <= '0;
            lane_idx            <= '0;
            state               <= WAIT_RDY;
          end
        end
        WAIT_RDY: if (udp_tx_data_out_ready) begin
          udp_tx_start <= 1'b1;
          state        <= START;
        end
        START: state <= res_err ? FLUSH : DATA;
        DATA: begin
          if (res_err) begin
            data_out_valid <= 1'b0;
            data_out_last  <= 1'b0;
            state          <= FLUSH;
          end else begin
            if (beat_take) begin
              beats_owed <= beats_owed - 16'd1;
              if (out_free) begin
                // Empty buffer and free output: lane 0 bypasses straight to
                // data_out so back-to-back beats leave no bubble.
                data_out       <= in_data[7:0];
                data_out_valid <= 1'b1;
                data_out_last  <= (rem == 16'd1);
                rem            <= rem - 16'd1;
                lane_buf       <= in_data;
                lane_idx       <= LW'(1);
                buf_cnt        <= beat_bytes - (LW+1)'(1);
              end else begin
                lane_buf <= in_data;
                lane_idx <= '0;
                buf_cnt  <= beat_bytes;
              end
            end else if (out_free && (buf_cnt != '0)) begin
              data_out       <= lane_buf[lane_idx];
              data_out_valid <= 1'b1;
              data_out_last  <= (rem == 16'd1);
              rem            <= rem - 16'd1;
              lane_idx       <= lane_idx + LW'(1);
              buf_cnt        <= buf_cnt - (LW+1)'(1);
            end else if (xfer) begin
              data_out_valid <= 1'b0;
              data_out_last  <= 1'b0;
            end
            if (xfer && data_out_last) begin
              state <= RESULT;
              tmo   <= '0;
            end
          end
        end
        RESULT: begin
          if (udp_tx_result == 2'b11) begin
            done_pulse <= 1'b1;
            pkt_cnt    <= pkt_cnt + 16'd1;
            state      <= IDLE;
          end else if (res_err || (tmo == TW'(RESULT_TIMEOUT - 1))) begin
            err_pulse <= 1'b1;
            err_cnt   <= err_cnt + 16'd1;
            state     <= IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        FLUSH: begin
          if (beat_take) beats_owed <= beats_owed - 16'd1;
          if (beats_owed == '0) begin
            err_pulse <= 1'b1;
            err_cnt   <= err_cnt + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
